// File: rtl/fifo_write_arbiter_if.sv
// Bundle of producer request/data/ack lines plus the FIFO write-side signals.
// The slave modport is the arbiter's view. The master modport is the view of the
// producers and FIFO that surround it.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]       ack_o;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_write_data_o;
  logic                     fifo_full_i;
  logic [CNT_WIDTH-1:0]     drop_count_o;
  logic                     drop_clear_i;

  modport slave (
    input  req_i, data_i, fifo_full_i, drop_clear_i,
    output ack_o, fifo_wr_en_o, fifo_write_data_o, drop_count_o
  );

  modport master (
    output req_i, data_i, fifo_full_i, drop_clear_i,
    input  ack_o, fifo_wr_en_o, fifo_write_data_o, drop_count_o
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the sample FIFO's single write port among
// NUM_REQ producers. A grant costs one IDLE cycle plus one ISSUE cycle, so the
// port accepts at most one word every two cycles. FIFO-full is either
// back-pressured or, with DROP_ON_FULL, acknowledged and counted as a drop.
module fifo_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH        = 8,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH    = 16
) (
  input logic                clk,
  input logic                rst_n,
  fifo_write_arbiter_if.slave arb_bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0] NUM_REQ_W = SUM_W'(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 wrEn_q, wrEn_d;
  logic [WIDTH-1:0]     wrData_q, wrData_d;
  logic [CNT_WIDTH-1:0] dropCount_q, dropCount_d;

  logic [WIDTH-1:0]     dataWord [NUM_REQ];
  logic [SUM_W-1:0]     candSum;
  logic                 winnerFound;
  logic [PTR_W-1:0]     winnerIdx;
  logic [PTR_W-1:0]     nextPtr;
  logic [CNT_WIDTH-1:0] dropBase;

  for (genvar k = 0; k < NUM_REQ; k++) begin : gUnpack
    assign dataWord[k] = arb_bus.data_i[k*WIDTH +: WIDTH];
  end

  // Search for the first active request at or after rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candSum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      candSum = {1'b0, rrPtr_q} + SUM_W'(i);
      if (candSum >= NUM_REQ_W) begin
        candSum = candSum - NUM_REQ_W;
      end
      if (!winnerFound && arb_bus.req_i[candSum[PTR_W-1:0]]) begin
        winnerFound = 1'b1;
        winnerIdx   = candSum[PTR_W-1:0];
      end
    end
  end

  assign nextPtr = (winnerIdx == LAST_IDX) ? '0 : winnerIdx + PTR_W'(1);

  // Next-state logic. A clear request always zeroes the hold value first, so a
  // drop in the same cycle counts from zero.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    ack_d       = '0;
    wrEn_d      = 1'b0;
    wrData_d    = wrData_q;
    dropBase    = arb_bus.drop_clear_i ? '0 : dropCount_q;
    dropCount_d = dropBase;
    case (state_q)
      IDLE: begin
        if (winnerFound) begin
          if (!arb_bus.fifo_full_i) begin
            state_d           = ISSUE;
            wrEn_d            = 1'b1;
            wrData_d          = dataWord[winnerIdx];
            ack_d[winnerIdx]  = 1'b1;
            rrPtr_d           = nextPtr;
          end else if (DROP_ON_FULL != 0) begin
            state_d          = ISSUE;
            ack_d[winnerIdx] = 1'b1;
            rrPtr_d          = nextPtr;
            if (dropBase != '1) begin
              dropCount_d = dropBase + CNT_WIDTH'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset during ISSUE drops the pending ack and write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      ack_q       <= '0;
      wrEn_q      <= 1'b0;
      wrData_q    <= '0;
      dropCount_q <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      ack_q       <= ack_d;
      wrEn_q      <= wrEn_d;
      wrData_q    <= wrData_d;
      dropCount_q <= dropCount_d;
    end
  end

  assign arb_bus.ack_o             = ack_q;
  assign arb_bus.fifo_wr_en_o      = wrEn_q;
  assign arb_bus.fifo_write_data_o = wrData_q;
  assign arb_bus.drop_count_o      = dropCount_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. There are three instances.
// busA uses back-pressure and drives a DEPTH=8 FIFO model.
// busB drops on full with a 16-bit counter.
// busC drops on full with a 2-bit counter, so saturation can be reached.
module tb_fifo_write_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic fifoRd    = 1'b0;
  logic fifoFlush = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   cycle     = 0;
  int   fifoCount = 0;
  logic [WIDTH-1:0] fifoQ[$];
  logic [WIDTH-1:0] wrLog[$];
  int               wrCycle[$];

  fifo_write_arbiter_if #(.NUM_REQ(2), .WIDTH(8), .CNT_WIDTH(16)) busA ();
  fifo_write_arbiter_if #(.NUM_REQ(2), .WIDTH(8), .CNT_WIDTH(16)) busB ();
  fifo_write_arbiter_if #(.NUM_REQ(2), .WIDTH(8), .CNT_WIDTH(2))  busC ();

  fifo_write_arbiter #(.NUM_REQ(2), .WIDTH(8), .DROP_ON_FULL(0), .CNT_WIDTH(16)) dutA (
    .clk(clk), .rst_n(rst_n), .arb_bus(busA.slave)
  );
  fifo_write_arbiter #(.NUM_REQ(2), .WIDTH(8), .DROP_ON_FULL(1), .CNT_WIDTH(16)) dutB (
    .clk(clk), .rst_n(rst_n), .arb_bus(busB.slave)
  );
  fifo_write_arbiter #(.NUM_REQ(2), .WIDTH(8), .DROP_ON_FULL(1), .CNT_WIDTH(2)) dutC (
    .clk(clk), .rst_n(rst_n), .arb_bus(busC.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  assign busA.fifo_full_i = (fifoCount == DEPTH);

  // Behavioural DEPTH=8 FIFO on busA's write side. It also logs every stored word and its cycle.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifoFlush) begin
      fifoQ.delete();
      wrLog.delete();
      wrCycle.delete();
      fifoCount <= 0;
    end else begin
      if (busA.fifo_wr_en_o && fifoCount < DEPTH) begin
        fifoQ.push_back(busA.fifo_write_data_o);
        wrLog.push_back(busA.fifo_write_data_o);
        wrCycle.push_back(cycle);
      end
      if (fifoRd && fifoCount > 0) begin
        void'(fifoQ.pop_front());
      end
      fifoCount <= fifoCount
                   + ((busA.fifo_wr_en_o && fifoCount < DEPTH) ? 1 : 0)
                   - ((fifoRd && fifoCount > 0) ? 1 : 0);
    end
  end

  // Safety net in case a wait ever stops making progress
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    busA.req_i = '0; busA.data_i = '0; busA.drop_clear_i = 1'b0;
    busB.req_i = '0; busB.data_i = '0; busB.drop_clear_i = 1'b0; busB.fifo_full_i = 1'b0;
    busC.req_i = '0; busC.data_i = '0; busC.drop_clear_i = 1'b0; busC.fifo_full_i = 1'b0;
    fifoRd = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n     = 1'b0;
    fifoFlush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    fifoFlush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n     = 1'b0;
    fifoFlush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (busA.ack_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_ackA: got %b expected 00", busA.ack_o); end
    checks++;
    if (busA.fifo_wr_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrenA: got %b expected 0", busA.fifo_wr_en_o); end
    checks++;
    if (busA.fifo_write_data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_dataA: got %h expected 00", busA.fifo_write_data_o); end
    checks++;
    if (busB.drop_count_o !== 16'd0) begin errors++; $display("[TB] FAIL reset_dropB: got %0d expected 0", busB.drop_count_o); end
    checks++;
    if (busC.drop_count_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_dropC: got %0d expected 0", busC.drop_count_o); end
    checks++;
    rst_n     = 1'b1;
    fifoFlush = 1'b0;
  endtask

  task automatic test_single_write();
    busA.req_i = 2'b01;
    busA.data_i[7:0] = 8'hA5;
    @(posedge clk); #1;
    if (busA.fifo_wr_en_o !== 1'b1) begin errors++; $display("[TB] FAIL single_wren: got %b expected 1", busA.fifo_wr_en_o); end
    checks++;
    if (busA.fifo_write_data_o !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected a5", busA.fifo_write_data_o); end
    checks++;
    if (busA.ack_o !== 2'b01) begin errors++; $display("[TB] FAIL single_ack: got %b expected 01", busA.ack_o); end
    checks++;
    busA.req_i = 2'b00;
    @(posedge clk); #1;
    if (busA.ack_o !== 2'b00 || busA.fifo_wr_en_o !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pulse: got ack %b wren %b expected 00/0", busA.ack_o, busA.fifo_wr_en_o);
    end
    checks++;
    if (busA.fifo_write_data_o !== 8'hA5) begin errors++; $display("[TB] FAIL single_hold: got %h expected a5", busA.fifo_write_data_o); end
    checks++;
    if (fifoQ.size() !== 1 || fifoQ[0] !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_fifo: got size %0d expected 1 word a5", fifoQ.size());
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] expAck [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [7:0] expWord [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    do_reset();
    busA.data_i = {8'h22, 8'h11};
    busA.req_i  = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busA.ack_o !== expAck[i]) begin errors++; $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", i, busA.ack_o, expAck[i]); end
      checks++;
      busA.req_i = ~busA.ack_o;
    end
    busA.req_i = 2'b00;
    repeat (2) @(posedge clk); #1;
    if (wrLog.size() !== 4) begin
      errors++; $display("[TB] FAIL rr_count: got %0d expected 4", wrLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wrLog[i] !== expWord[i]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %h expected %h", i, wrLog[i], expWord[i]); end
        checks++;
      end
      for (int i = 1; i < 4; i++) begin
        if (wrCycle[i] - wrCycle[i-1] !== 2) begin
          errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d expected 2", i, wrCycle[i] - wrCycle[i-1]);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_hold_on_full();
    do_reset();
    for (int j = 0; j < DEPTH; j++) begin
      busA.req_i = 2'b01;
      busA.data_i[7:0] = 8'h30 + 8'(j);
      @(posedge clk); #1;
      if (busA.ack_o !== 2'b01) begin errors++; $display("[TB] FAIL fill_ack[%0d]: got %b expected 01", j, busA.ack_o); end
      checks++;
      busA.req_i = 2'b00;
      @(posedge clk); #1;
    end
    busA.req_i = 2'b10;
    busA.data_i[15:8] = 8'h77;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (busA.ack_o !== 2'b00 || busA.fifo_wr_en_o !== 1'b0) begin
        errors++; $display("[TB] FAIL full_hold[%0d]: got ack %b wren %b expected 00/0", j, busA.ack_o, busA.fifo_wr_en_o);
      end
      checks++;
    end
    fifoRd = 1'b1;
    @(posedge clk); #1;
    fifoRd = 1'b0;
    if (busA.ack_o !== 2'b00) begin errors++; $display("[TB] FAIL full_read_ack0: got %b expected 00", busA.ack_o); end
    checks++;
    @(posedge clk); #1;
    if (busA.ack_o !== 2'b10 || busA.fifo_wr_en_o !== 1'b1 || busA.fifo_write_data_o !== 8'h77) begin
      errors++; $display("[TB] FAIL full_release: got ack %b wren %b data %h expected 10/1/77",
                         busA.ack_o, busA.fifo_wr_en_o, busA.fifo_write_data_o);
    end
    checks++;
    busA.req_i = 2'b00;
    @(posedge clk); #1;
    if (fifoCount !== DEPTH || wrLog[wrLog.size()-1] !== 8'h77) begin
      errors++; $display("[TB] FAIL full_stored: got count %0d last %h expected 8/77", fifoCount, wrLog[wrLog.size()-1]);
    end
    checks++;
    if (busA.drop_count_o !== 16'd0) begin errors++; $display("[TB] FAIL full_nodrop: got %0d expected 0", busA.drop_count_o); end
    checks++;
  endtask

  task automatic test_drop_on_full();
    logic [1:0] expAck [6]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    int         expDrop [6] = '{1, 1, 2, 2, 3, 3};
    do_reset();
    busB.fifo_full_i = 1'b1;
    busB.data_i      = {8'h44, 8'h33};
    busB.req_i       = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busB.ack_o !== expAck[i] || busB.fifo_wr_en_o !== 1'b0) begin
        errors++; $display("[TB] FAIL drop_ack[%0d]: got ack %b wren %b expected %b/0", i, busB.ack_o, busB.fifo_wr_en_o, expAck[i]);
      end
      checks++;
      if (busB.drop_count_o !== 16'(expDrop[i])) begin
        errors++; $display("[TB] FAIL drop_count[%0d]: got %0d expected %0d", i, busB.drop_count_o, expDrop[i]);
      end
      checks++;
      busB.req_i = ~busB.ack_o;
    end
    busB.req_i        = 2'b00;
    busB.drop_clear_i = 1'b1;
    @(posedge clk); #1;
    if (busB.drop_count_o !== 16'd0) begin errors++; $display("[TB] FAIL drop_clear: got %0d expected 0", busB.drop_count_o); end
    checks++;
    busB.req_i = 2'b01;
    @(posedge clk); #1;
    if (busB.drop_count_o !== 16'd1 || busB.ack_o !== 2'b01) begin
      errors++; $display("[TB] FAIL drop_clear_coincident: got count %0d ack %b expected 1/01", busB.drop_count_o, busB.ack_o);
    end
    checks++;
    busB.req_i        = 2'b00;
    busB.drop_clear_i = 1'b0;
    @(posedge clk); #1;
    if (busB.drop_count_o !== 16'd1) begin errors++; $display("[TB] FAIL drop_hold: got %0d expected 1", busB.drop_count_o); end
    checks++;
  endtask

  task automatic test_saturation();
    logic [1:0] expDrop [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    busC.fifo_full_i = 1'b1;
    busC.data_i      = {8'h00, 8'h5C};
    for (int i = 0; i < 5; i++) begin
      busC.req_i = 2'b01;
      @(posedge clk); #1;
      if (busC.ack_o !== 2'b01 || busC.fifo_wr_en_o !== 1'b0) begin
        errors++; $display("[TB] FAIL sat_ack[%0d]: got ack %b wren %b expected 01/0", i, busC.ack_o, busC.fifo_wr_en_o);
      end
      checks++;
      if (busC.drop_count_o !== expDrop[i]) begin
        errors++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", i, busC.drop_count_o, expDrop[i]);
      end
      checks++;
      busC.req_i = 2'b00;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    busA.data_i = {8'h00, 8'h5A};
    busA.req_i  = 2'b01;
    @(posedge clk); #1;
    if (busA.ack_o !== 2'b01) begin errors++; $display("[TB] FAIL rst_issue_ack: got %b expected 01", busA.ack_o); end
    checks++;
    rst_n      = 1'b0;
    busA.req_i = 2'b00;
    @(posedge clk); #1;
    if (busA.ack_o !== 2'b00 || busA.fifo_wr_en_o !== 1'b0 || busA.fifo_write_data_o !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_abort: got ack %b wren %b data %h expected 00/0/00",
                         busA.ack_o, busA.fifo_wr_en_o, busA.fifo_write_data_o);
    end
    checks++;
    rst_n       = 1'b1;
    busA.data_i = {8'h62, 8'h61};
    busA.req_i  = 2'b11;
    @(posedge clk); #1;
    if (busA.ack_o !== 2'b01 || busA.fifo_write_data_o !== 8'h61) begin
      errors++; $display("[TB] FAIL rst_ptr: got ack %b data %h expected 01/61", busA.ack_o, busA.fifo_write_data_o);
    end
    checks++;
    busA.req_i = 2'b00;
    repeat (2) @(posedge clk); #1;
  endtask

  // Run every scenario in order and report the totals
  initial begin
    $display("[TB] starting fifo_write_arbiter bench");
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hold_on_full();
    test_drop_on_full();
    test_saturation();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
